i2s_capture: RTL



---
 rtl/i2s_capture.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/i2s_capture.sv
// I2S / left-justified serial audio receiver on a single system clock.
// Inputs are synchronised and bclk is debounced. Words are paired L/R, and the output is muted when bclk stops.
module i2s_capture #(
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i2s_bclk,
    input  logic                i2s_ws,
    input  logic                i2s_data,
    input  logic                mode_lj,
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic                sample_valid,
    output logic                locked,
    output logic [5:0]          word_bits
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);
    localparam logic [SAMPLE_W-1:0] MSB_ONE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic {HUNT, RECV} state_t;

    // Synchroniser chain carrying {bclk, ws, data} together.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic [2:0] stage_q;
        if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) stage_q <= '0;
                else          stage_q <= {i2s_bclk, i2s_ws, i2s_data};
            end
        end else begin : g_rest
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) stage_q <= '0;
                else          stage_q <= g_sync[gi-1].stage_q;
            end
        end
    end

    logic bclk_s, ws_s, data_s;
    assign {bclk_s, ws_s, data_s} = g_sync[SYNC_STAGES-1].stage_q;

    logic                bclk_prev_q, bclk_db_q, bclk_db_d, rise;
    state_t              state_q, state_d;
    logic                ws_prev_q, ws_prev_d, ws_seen_q, ws_seen_d;
    logic                mode_q, mode_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d, shift_ins, bit_mask, new_msb, commit_word;
    logic [5:0]          cnt_q, cnt_d, cnt_inc, commit_bits;
    logic [SAMPLE_W-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic                have_l_q, have_l_d;
    logic [SAMPLE_W-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
    logic                valid_q, valid_d, locked_q, locked_d;
    logic [5:0]          word_bits_q, word_bits_d;
    logic [TW-1:0]       tmo_q, tmo_d;

    // Debounce: the level only follows two agreeing synced samples.
    always_comb begin
        bclk_db_d   = (bclk_s == bclk_prev_q) ? bclk_s : bclk_db_q;
        rise        = bclk_db_d & ~bclk_db_q;
        bit_mask    = MSB_ONE >> cnt_q;
        shift_ins   = shift_q | (bit_mask & {SAMPLE_W{data_s}});
        new_msb     = MSB_ONE & {SAMPLE_W{data_s}};
        cnt_inc     = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
        commit_word = mode_q ? shift_q : shift_ins;
        commit_bits = mode_q ? cnt_q : cnt_inc;
    end

    always_comb begin
        state_d     = state_q;
        ws_prev_d   = ws_prev_q;
        ws_seen_d   = ws_seen_q;
        mode_d      = mode_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        have_l_d    = have_l_q;
        sample_l_d  = sample_l_q;
        sample_r_d  = sample_r_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        word_bits_d = word_bits_q;
        tmo_d       = (tmo_q == TMO) ? tmo_q : tmo_q + TW'(1);

        if (rise) begin
            tmo_d     = '0;
            ws_prev_d = ws_s;
            ws_seen_d = 1'b1;
            if (state_q == HUNT) begin
                // The very first sampled ws after reset is not a transition.
                if (ws_seen_q && (ws_s != ws_prev_q)) begin
                    state_d = RECV;
                    mode_d  = mode_lj;
                    shift_d = mode_lj ? new_msb : '0;
                    cnt_d   = mode_lj ? 6'd1 : 6'd0;
                end
            end else if (ws_s != ws_prev_q) begin
                word_bits_d = commit_bits;
                if (!ws_prev_q) begin
                    pend_l_d = commit_word;
                    have_l_d = 1'b1;
                end else begin
                    pend_r_d = commit_word;
                    if (have_l_q) begin
                        sample_l_d = pend_l_q;
                        sample_r_d = commit_word;
                        valid_d    = 1'b1;
                        have_l_d   = 1'b0;
                        locked_d   = 1'b1;
                    end
                end
                mode_d  = mode_lj;
                shift_d = mode_q ? new_msb : '0;
                cnt_d   = mode_q ? 6'd1 : 6'd0;
            end else begin
                shift_d = shift_ins;
                cnt_d   = cnt_inc;
            end
        end else if (tmo_q == TMO) begin
            state_d    = HUNT;
            ws_seen_d  = 1'b0;
            sample_l_d = '0;
            sample_r_d = '0;
            locked_d   = 1'b0;
            have_l_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_prev_q <= 1'b0;
            bclk_db_q   <= 1'b0;
            state_q     <= HUNT;
            ws_prev_q   <= 1'b0;
            ws_seen_q   <= 1'b0;
            mode_q      <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            pend_l_q    <= '0;
            pend_r_q    <= '0;
            have_l_q    <= 1'b0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            word_bits_q <= '0;
            tmo_q       <= '0;
        end else begin
            bclk_prev_q <= bclk_s;
            bclk_db_q   <= bclk_db_d;
            state_q     <= state_d;
            ws_prev_q   <= ws_prev_d;
            ws_seen_q   <= ws_seen_d;
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            have_l_q    <= have_l_d;
            sample_l_q  <= sample_l_d;
            sample_r_q  <= sample_r_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            word_bits_q <= word_bits_d;
            tmo_q       <= tmo_d;
        end
    end

    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = valid_q;
    assign locked       = locked_q;
    assign word_bits    = word_bits_q;

endmodule
